serial_bit_feeder: RTL
======================

Name: serial_bit_feeder

Overview:
Upstream stage of the 1011 sequence detector. It takes parallel words through a valid/ready handshake and serializes them one bit per clock onto the detector's din input. A shift register plus one holding register let consecutive words stream with no idle gap, so patterns that span a word boundary (e.g. overlapping 1011011) still reach the detector intact.

Parameters:
WIDTH, 8, bits per input word (>=2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
IDLE_BIT, 0, value driven on din_out when no bit is valid

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
data_in  in  WIDTH  parallel word to serialize
data_valid  in  1  data_in is valid
data_ready  out  1  block can accept a word this cycle
din_out  out  1  serial bit, connects to the detector's din
bit_valid  out  1  din_out carries a real data bit
word_done  out  1  one-cycle pulse coinciding with the last bit of a word
busy  out  1  shift register or holding register occupied

Behaviour:
- Reset (sampled at posedge clock, reset=1): every register clears. Outputs the following cycle: din_out=IDLE_BIT, bit_valid=0, word_done=0, busy=0, data_ready=1. Words in flight are discarded and produce no word_done.
- Storage: shift register SR (WIDTH bits), bit counter cnt (0..WIDTH-1), holding register HR with flag hold_full.
- FSM states:
  - IDLE: SR empty.
  - SHIFT: SR is emitting bits.
- Handshake:
  - Accept = data_valid && data_ready at a posedge.
  - data_ready = !hold_full. This is a combinational function of registered state only, with no path from data_valid.
  - data_in must be held stable while data_valid=1 and data_ready=0. No word is lost or duplicated.
- IDLE + accept: word loads directly into SR, cnt=0, go to SHIFT. The first bit appears on din_out in the cycle after the accepting edge (latency 1). All outputs are registered.
- SHIFT:
  - Each posedge advances one bit and increments cnt.
  - din_out = SR bit selected by MSB_FIRST. bit_valid=1.
- SHIFT + accept while not on the last bit: word goes into HR and hold_full=1.
- Last bit (cnt=WIDTH-1): word_done=1 in that same cycle. At the following edge, in priority order:
  - hold_full=1: HR moves into SR, hold_full clears, cnt=0, stay in SHIFT. The gap is zero cycles.
  - hold_full=0 and accept at this edge: the incoming word bypasses HR into SR, stay in SHIFT. The gap is zero cycles.
  - Otherwise: go to IDLE. Next cycle din_out=IDLE_BIT, bit_valid=0.
- Last bit with hold_full=1 and data_valid=1: data_ready=0, so the new word is not accepted that cycle. It is accepted at the next edge into HR (SR is then in SHIFT).
- Throughput: one word per WIDTH cycles sustained. Maximum occupancy is 2 words.
- busy = (state==SHIFT) || hold_full.
- cnt width is clog2(WIDTH). It wraps to 0 only on a load, never past WIDTH-1.

Test Plan:
- Single word, MSB_FIRST=1: data_in=8'hB0 accepted at edge k → din_out = 1,0,1,1,0,0,0,0 in cycles k+1..k+8. bit_valid high exactly 8 cycles. word_done high only in cycle k+8. Detector dout pulses once.
- Back-to-back words: 8'hB6 then 8'hD0 with data_valid held high → 16 contiguous valid bits, no gap. data_ready drops to 0 while HR is full. The 1011011 overlap across bits 0-6 gives the detector two detections.
- Last-edge bypass: present the second word exactly at the last-bit edge with HR empty → it is accepted, its first bit follows with a zero-cycle gap, and hold_full is never set.
- Reset mid-word: assert reset after 3 bits of 8'hFF → next cycle din_out=0, bit_valid=0, busy=0, data_ready=1, and no word_done for the aborted word.
- MSB_FIRST=0: data_in=8'h0D → din_out = 1,0,1,1,0,0,0,0.
- Backpressure: data_valid high with 3 queued words → each word is transferred exactly once, in order. Total 24 valid bits, 3 word_done pulses.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Purpose: serializes parallel words onto a one-bit stream (detector din), one bit per clock.
// Latency: first bit on din_out the cycle after the accepting edge; consecutive words stream with no gap.
// Backpressure: data_ready = !hold_full; one holding word behind the shift register, so at most 2 words in flight.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   data_in/valid     parallel word and its valid, accepted when data_ready is high
//   data_ready        block can accept a word this cycle (registered state only)
//   din_out           serial bit, IDLE_BIT when no bit is valid
//   bit_valid         din_out carries a real data bit
//   word_done         pulse during the last bit of each word
//   busy              shift register or holding register occupied
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             din_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hr_q, hr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shifted;

  // Ready depends only on the holding flag, never on data_valid.
  assign accept   = data_valid && !hold_full_q;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  // The outgoing bit always sits at the end selected by MSB_FIRST.
  assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sr_q[WIDTH-1:1]};

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      hr_q        <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hr_q        <= hr_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hr_d        = hr_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Reload priority: held word first, then a word arriving on this edge.
          // hold_full implies data_ready=0, so both cannot happen together.
          if (hold_full_q) begin
            sr_d        = hr_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (accept) begin
            sr_d  = data_in;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sr_d  = sr_shifted;
          cnt_d = cnt_q + CNT_W'(1);
          if (accept) begin
            hr_d        = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registers only
  always_comb begin
    data_ready = !hold_full_q;
    bit_valid  = (state_q == SHIFT);
    word_done  = last_bit;
    busy       = (state_q == SHIFT) || hold_full_q;
    din_out    = IDLE_BIT;
    if (state_q == SHIFT) begin
      din_out = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
    end
  end

endmodule
